align_shifter_seq: RTL and testbench

- Pre-add alignment stage of the sequential IEEE-754 single-precision adder. Sits directly downstream of the exponent comparator.
- Consumes the comparator's larger-exponent operand, smaller-exponent operand and 9-bit exponent difference.
- Shifts the smaller operand's significand right by that difference, one bit per clock, and collects guard/round/sticky bits.
- Hands aligned significands to the significand add/sub stage over a valid/ready handshake.

---
 rtl/align_shifter_seq.sv | 108 ++++++++++
 tb/tb_align_shifter_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/align_shifter_seq.sv
// align_shifter_seq: pre-add alignment stage of the sequential single-precision
// adder. Captures the larger/smaller exponent operands, shifts the smaller
// significand right one bit per clock by the exponent difference (saturated at
// MAX_SHIFT), folding shifted-out bits into sticky, then presents both
// significands to the add/sub stage over a valid/ready handshake.
module align_shifter_seq #(
    parameter int unsigned MAX_SHIFT = 26,
    parameter int unsigned GRS_W     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] big_i,
    input  logic [31:0] little_i,
    input  logic [8:0]  dif_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_big,
    output logic        sign_little,
    output logic [7:0]  exp_big,
    output logic [26:0] mant_big,
    output logic [26:0] mant_little,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [4:0] cnt;

    logic       hid_big;
    logic       hid_little;
    logic [4:0] cnt_load;

    // Hidden bits and saturated shift count for the operand set being offered
    always_comb begin
        hid_big    = |big_i[30:23];
        hid_little = |little_i[30:23];
        if (dif_i >= 9'(MAX_SHIFT)) begin
            cnt_load = 5'(MAX_SHIFT);
        end else begin
            cnt_load = dif_i[4:0];
        end
    end

    // Control FSM with registered handshake outputs and the alignment shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            sign_big    <= 1'b0;
            sign_little <= 1'b0;
            exp_big     <= '0;
            mant_big    <= '0;
            mant_little <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_big    <= big_i[31];
                        sign_little <= little_i[31];
                        exp_big     <= big_i[30:23];
                        mant_big    <= {hid_big, big_i[22:0], {GRS_W{1'b0}}};
                        mant_little <= {hid_little, little_i[22:0], {GRS_W{1'b0}}};
                        cnt         <= cnt_load;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        if (cnt_load == 5'd0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // bit 0 is sticky: it absorbs everything shifted past it
                    mant_little <= {1'b0, mant_little[26:2], mant_little[1] | mant_little[0]};
                    cnt         <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_align_shifter_seq.sv
// tb_align_shifter_seq: directed self-checking bench for align_shifter_seq.
module tb_align_shifter_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] big_i = '0;
    logic [31:0] little_i = '0;
    logic [8:0]  dif_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_big;
    logic        sign_little;
    logic [7:0]  exp_big;
    logic [26:0] mant_big;
    logic [26:0] mant_little;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    align_shifter_seq #(.MAX_SHIFT(26), .GRS_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .big_i(big_i), .little_i(little_i), .dif_i(dif_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_big(sign_big), .sign_little(sign_little),
        .exp_big(exp_big), .mant_big(mant_big), .mant_little(mant_little),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Offer one operand set from IDLE, then count edges from accept until out_valid.
    // Inputs are scrambled after the accept edge to show they are not resampled.
    task automatic run_op(input logic [31:0] b, input logic [31:0] l,
                          input logic [8:0] d, output int edges);
        @(negedge clk);
        big_i = b; little_i = l; dif_i = d; in_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        big_i = $urandom; little_i = $urandom; dif_i = 9'($urandom);
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    // Complete the output handshake so the DUT returns to IDLE.
    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if ({out_valid, busy, sign_big, sign_little} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, sign_big, sign_little});
        else n_pass++;
        n_total++;
        if ({exp_big, mant_big, mant_little} !== 62'd0)
            $display("FAIL reset_data: got %h want 0", {exp_big, mant_big, mant_little});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dif0();
        int e;
        run_op(32'h40000000, 32'h3F800000, 9'd0, e);
        n_total++;
        if (e !== 1) $display("FAIL dif0_latency: got %0d want 1", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h4000000) $display("FAIL dif0_little: got %h want 4000000", mant_little);
        else n_pass++;
        n_total++;
        if (mant_big !== 27'h4000000) $display("FAIL dif0_big: got %h want 4000000", mant_big);
        else n_pass++;
        n_total++;
        if (exp_big !== 8'h80) $display("FAIL dif0_exp: got %h want 80", exp_big);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_dif1();
        int e;
        run_op(32'h40400000, 32'h3F800000, 9'd1, e);
        n_total++;
        if (e !== 2) $display("FAIL dif1_latency: got %0d want 2", e);
        else n_pass++;
        n_total++;
        if (mant_big !== 27'h6000000) $display("FAIL dif1_big: got %h want 6000000", mant_big);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h2000000) $display("FAIL dif1_little: got %h want 2000000", mant_little);
        else n_pass++;
        n_total++;
        if ({exp_big, sign_big, sign_little} !== {8'h80, 2'b00})
            $display("FAIL dif1_exp_signs: got %h/%b%b want 80/00", exp_big, sign_big, sign_little);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_sticky();
        int e;
        run_op(32'h40000000, 32'h3FFFFFFF, 9'd4, e);
        n_total++;
        if (e !== 5) $display("FAIL sticky4_latency: got %0d want 5", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h07FFFFF) $display("FAIL sticky4_little: got %h want 07FFFFF", mant_little);
        else n_pass++;
        finish_op();
        run_op(32'h40000000, 32'h3FFFFFFF, 9'd3, e);
        n_total++;
        if (e !== 4) $display("FAIL sticky3_latency: got %0d want 4", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h0FFFFFF) $display("FAIL sticky3_little: got %h want 0FFFFFF", mant_little);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_saturation();
        int e;
        run_op(32'h40000000, 32'h3F800000, 9'd30, e);
        n_total++;
        if (e !== 27) $display("FAIL sat30_latency: got %0d want 27", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h0000001) $display("FAIL sat30_little: got %h want 0000001", mant_little);
        else n_pass++;
        finish_op();
        run_op(32'h40000000, 32'h3F800000, 9'd300, e);
        n_total++;
        if (e !== 27) $display("FAIL sat300_latency: got %0d want 27", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h0000001) $display("FAIL sat300_little: got %h want 0000001", mant_little);
        else n_pass++;
        finish_op();
        run_op(32'h40000000, 32'h00000000, 9'd30, e);
        n_total++;
        if (e !== 27) $display("FAIL satzero_latency: got %0d want 27", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h0000000) $display("FAIL satzero_little: got %h want 0000000", mant_little);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_back_pressure();
        int e;
        run_op(32'hC0400000, 32'hBF800000, 9'd1, e);
        n_total++;
        if ({sign_big, sign_little, mant_big, mant_little} !== {2'b11, 27'h6000000, 27'h2000000})
            $display("FAIL bp_first: got %b%b %h %h want 11 6000000 2000000",
                     sign_big, sign_little, mant_big, mant_little);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            big_i = 32'h3F800000; little_i = 32'h3F000000; dif_i = 9'd0;
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if ({out_valid, in_ready, busy, sign_big, sign_little, exp_big, mant_big, mant_little}
                !== {5'b10111, 8'h80, 27'h6000000, 27'h2000000})
                $display("FAIL bp_hold_%0d: got %b%b%b%b%b %h %h %h want 10111 80 6000000 2000000", i,
                         out_valid, in_ready, busy, sign_big, sign_little, exp_big, mant_big, mant_little);
            else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL bp_release: got %b want 010", {out_valid, in_ready, busy});
        else n_pass++;
        run_op(32'h40000000, 32'h3FFFFFFF, 9'd3, e);
        n_total++;
        if (e !== 4 || mant_little !== 27'h0FFFFFF || sign_little !== 1'b0)
            $display("FAIL bp_next_op: got %0d %h %b want 4 0FFFFFF 0", e, mant_little, sign_little);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_reset_mid_shift();
        int e;
        @(negedge clk);
        big_i = 32'h40400000; little_i = 32'h3F800000; dif_i = 9'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_total++;
        if ({busy, in_ready, out_valid} !== 3'b100)
            $display("FAIL midshift_state: got %b want 100", {busy, in_ready, out_valid});
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, busy, in_ready} !== 3'b001)
            $display("FAIL midreset_flags: got %b want 001", {out_valid, busy, in_ready});
        else n_pass++;
        n_total++;
        if ({exp_big, mant_big, mant_little} !== 62'd0)
            $display("FAIL midreset_data: got %h want 0", {exp_big, mant_big, mant_little});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h40400000, 32'h3F800000, 9'd2, e);
        n_total++;
        if (e !== 3) $display("FAIL postreset_latency: got %0d want 3", e);
        else n_pass++;
        n_total++;
        if (mant_little !== 27'h1000000 || mant_big !== 27'h6000000)
            $display("FAIL postreset_data: got %h %h want 1000000 6000000", mant_little, mant_big);
        else n_pass++;
        finish_op();
    endtask

    initial begin
        test_reset();
        test_dif0();
        test_dif1();
        test_sticky();
        test_saturation();
        test_back_pressure();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
